csr_trap_ctrl: RTL

Sequencing controller for the machine-mode CSR file (mtvec/mepc/mcause). Accepts one request at a time from the execute stage: a Zicsr op (CSRRW/CSRRS/CSRRC), an ECALL trap entry, or an MRET.
- Zicsr ops: performs read-modify-write on the CSR file.
- ECALL/MRET: drives the direct mepc/mcause write ports and issues a PC redirect to the fetch stage.
- Owns the only write path into the CSR file, so all CSR updates are serialized.

---
 rtl/csr_trap_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR sequencer: Zicsr read-modify-write, ECALL entry, MRET.
// Sole writer of the CSR file, so every CSR update is serialized here.
module csr_trap_ctrl #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] ECALL_CAUSE = 64'd11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_csr_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [XLEN-1:0] req_pc,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy,
  output logic [11:0]     csr_read_address,
  input  logic [XLEN-1:0] csr_read_result,
  output logic [11:0]     csr_write_address,
  output logic [XLEN-1:0] csr_write_data,
  output logic            csr_write_en,
  output logic [XLEN-1:0] mepc_in,
  output logic            mepc_wen,
  output logic [XLEN-1:0] mcause_in,
  output logic            mcause_wen,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CSR_RD    = 3'd1;
  localparam logic [2:0] CSR_WR    = 3'd2;
  localparam logic [2:0] RESP      = 3'd3;
  localparam logic [2:0] TRAP_SAVE = 3'd4;
  localparam logic [2:0] TRAP_JUMP = 3'd5;
  localparam logic [2:0] MRET_JUMP = 3'd6;

  localparam logic [2:0] OP_RW   = 3'b001;
  localparam logic [2:0] OP_RS   = 3'b010;
  localparam logic [2:0] OP_RC   = 3'b011;
  localparam logic [2:0] OP_ECALL = 3'b100;
  localparam logic [2:0] OP_MRET = 3'b101;

  localparam logic [XLEN-1:0] ALIGN_MASK =
    ~{{(XLEN-2){1'b0}}, 2'b11};

  logic [2:0]      state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] old_q;
  logic [XLEN-1:0] new_val;
  logic            is_zicsr;
  logic            is_ecall;
  logic            is_mret;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign is_zicsr = (req_op == OP_RW) || (req_op == OP_RS) ||
                    (req_op == OP_RC);
  assign is_ecall = (req_op == OP_ECALL);
  assign is_mret  = (req_op == OP_MRET);

  always_comb begin
    new_val = wdata_q;
    unique case (op_q)
      OP_RS:   new_val = csr_read_result | wdata_q;
      OP_RC:   new_val = csr_read_result & ~wdata_q;
      default: new_val = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      op_q              <= '0;
      wdata_q           <= '0;
      old_q             <= '0;
      resp_valid        <= 1'b0;
      resp_rdata        <= '0;
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      csr_read_address  <= '0;
      csr_write_address <= '0;
      csr_write_data    <= '0;
      csr_write_en      <= 1'b0;
      mepc_in           <= '0;
      mepc_wen          <= 1'b0;
      mcause_in         <= '0;
      mcause_wen        <= 1'b0;
    end else begin
      resp_valid     <= 1'b0;
      redirect_valid <= 1'b0;
      csr_write_en   <= 1'b0;
      mepc_wen       <= 1'b0;
      mcause_wen     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            wdata_q <= req_wdata;
            unique case (1'b1)
              is_zicsr: begin
                state            <= CSR_RD;
                csr_read_address <= req_csr_addr;
              end
              is_ecall: begin
                state      <= TRAP_SAVE;
                mepc_in    <= req_pc;
                mepc_wen   <= 1'b1;
                mcause_in  <= ECALL_CAUSE;
                mcause_wen <= 1'b1;
              end
              is_mret: begin
                state          <= MRET_JUMP;
                redirect_valid <= 1'b1;
                redirect_pc    <= mepc;
              end
              default: begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_rdata <= '0;
              end
            endcase
          end
        end
        CSR_RD: begin
          state             <= CSR_WR;
          old_q             <= csr_read_result;
          csr_write_address <= csr_read_address;
          csr_write_data    <= new_val;
          // set/clear with a zero mask must not touch the CSR
          csr_write_en      <= (op_q == OP_RW) || (wdata_q != '0);
        end
        CSR_WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= old_q;
        end
        TRAP_SAVE: begin
          state          <= TRAP_JUMP;
          redirect_valid <= 1'b1;
          redirect_pc    <= mtvec & ALIGN_MASK;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
